// File: rtl/gray_defs.sv
// Shared definitions for the Gray-code stream checker: FSM encoding,
// default widths and the Gray-to-binary decode helper.
package gray_defs;

  localparam int GRAY_MAX_W = 16;
  localparam int GRAY_W_HI  = 4;
  localparam int GRAY_W_LO  = 3;
  localparam int DEF_ERR_W  = 8;

  typedef enum logic {
    ST_UNINIT = 1'b0,
    ST_TRACK  = 1'b1
  } chk_state_t;

  // Binary bit idx is the XOR of all Gray bits at or above idx, which is
  // the closed form of b[W-1]=g[W-1], b[i]=b[i+1]^g[i] (upper bits are zero).
  function automatic logic gray2bin_bit(input logic [GRAY_MAX_W-1:0] g, input int idx);
    logic b;
    b = 1'b0;
    for (int k = 0; k < GRAY_MAX_W; k++) begin
      if (k >= idx) b = b ^ g[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_channel_checker.sv
// One Gray stream checker: decodes to binary, classifies each sample as
// hold / legal step / illegal jump, reports direction and wrap, counts errors.
module gray_channel_checker
  import gray_defs::*;
#(
  parameter int W     = GRAY_W_HI,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [W-1:0]     gray_in,
  input  logic             clr_err,
  output logic [W-1:0]     bin,
  output logic             step,
  output logic             dir,
  output logic             wrap,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [W-1:0] BIN_MAX = '1;

  chk_state_t       r_state;
  chk_state_t       w_state_next;
  logic [W-1:0]     r_gray_prev;
  logic [W-1:0]     w_gray_prev_next;
  logic [W-1:0]     r_bin;
  logic [W-1:0]     w_bin_next;
  logic             r_dir;
  logic             w_dir_next;
  logic             r_step;
  logic             w_step_next;
  logic             r_wrap;
  logic             w_wrap_next;
  logic             r_err;
  logic             w_err_next;
  logic             w_err_inc;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] w_err_cnt_next;

  logic [GRAY_MAX_W-1:0] w_gray_ext;
  logic [W-1:0]          w_bin_new;
  logic [W-1:0]          w_bin_inc;
  logic [W-1:0]          w_diff;
  logic                  w_hold;
  logic                  w_legal;
  logic                  w_illegal;
  logic                  w_err_sat;

  assign w_gray_ext = GRAY_MAX_W'(gray_in);

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_decode
      assign w_bin_new[gi] = gray2bin_bit(w_gray_ext, gi);
    end
  endgenerate

  assign w_diff    = gray_in ^ r_gray_prev;
  assign w_hold    = (w_diff == '0);
  assign w_legal   = $onehot(w_diff);
  assign w_illegal = !w_hold && !w_legal;
  assign w_bin_inc = r_bin + W'(1);
  assign w_err_sat = &r_err_cnt;

  always_comb begin
    w_state_next     = r_state;
    w_gray_prev_next = r_gray_prev;
    w_bin_next       = r_bin;
    w_dir_next       = r_dir;
    w_step_next      = 1'b0;
    w_wrap_next      = 1'b0;
    w_err_next       = 1'b0;
    w_err_inc        = 1'b0;
    if (sample_en) begin
      case (r_state)
        ST_UNINIT: begin
          // First sample after reset only establishes the reference.
          w_gray_prev_next = gray_in;
          w_bin_next       = w_bin_new;
          w_state_next     = ST_TRACK;
        end
        ST_TRACK: begin
          if (w_legal) begin
            w_step_next      = 1'b1;
            w_gray_prev_next = gray_in;
            w_bin_next       = w_bin_new;
            w_dir_next       = (w_bin_new == w_bin_inc);
            w_wrap_next      = ((r_bin == BIN_MAX) && (w_bin_new == '0)) ||
                               ((r_bin == '0) && (w_bin_new == BIN_MAX));
          end else if (w_illegal) begin
            // Resynchronise to the new value; direction is left as it was.
            w_err_next       = 1'b1;
            w_err_inc        = 1'b1;
            w_gray_prev_next = gray_in;
            w_bin_next       = w_bin_new;
          end
        end
        default: w_state_next = ST_UNINIT;
      endcase
    end
  end

  always_comb begin
    w_err_cnt_next = r_err_cnt;
    if (clr_err) begin
      w_err_cnt_next = '0;
    end else if (w_err_inc && !w_err_sat) begin
      w_err_cnt_next = r_err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_UNINIT;
      r_gray_prev <= '0;
      r_bin       <= '0;
      r_dir       <= 1'b0;
      r_step      <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gray_prev <= w_gray_prev_next;
      r_bin       <= w_bin_next;
      r_dir       <= w_dir_next;
      r_step      <= w_step_next;
      r_wrap      <= w_wrap_next;
      r_err       <= w_err_next;
      r_err_cnt   <= w_err_cnt_next;
    end
  end

  assign bin     = r_bin;
  assign step    = r_step;
  assign dir     = r_dir;
  assign wrap    = r_wrap;
  assign err     = r_err;
  assign err_cnt = r_err_cnt;

endmodule

// File: rtl/dual_gray_checker.sv
// Consumer-side decoder/protocol checker for the 4-bit and 3-bit Gray
// streams of the dual Gray counter; the two channels are independent.
module dual_gray_checker
  import gray_defs::*;
#(
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [GRAY_W_HI-1:0] gray_4,
  input  logic [GRAY_W_LO-1:0] gray_3,
  input  logic                 clr_err,
  output logic [GRAY_W_HI-1:0] bin_4,
  output logic [GRAY_W_LO-1:0] bin_3,
  output logic                 step_4,
  output logic                 step_3,
  output logic                 dir_4,
  output logic                 dir_3,
  output logic                 wrap_4,
  output logic                 wrap_3,
  output logic                 err_4,
  output logic                 err_3,
  output logic [ERR_W-1:0]     err_cnt_4,
  output logic [ERR_W-1:0]     err_cnt_3
);

  gray_channel_checker #(
    .W     (GRAY_W_HI),
    .ERR_W (ERR_W)
  ) u_ch4 (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .gray_in   (gray_4),
    .clr_err   (clr_err),
    .bin       (bin_4),
    .step      (step_4),
    .dir       (dir_4),
    .wrap      (wrap_4),
    .err       (err_4),
    .err_cnt   (err_cnt_4)
  );

  gray_channel_checker #(
    .W     (GRAY_W_LO),
    .ERR_W (ERR_W)
  ) u_ch3 (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .gray_in   (gray_3),
    .clr_err   (clr_err),
    .bin       (bin_3),
    .step      (step_3),
    .dir       (dir_3),
    .wrap      (wrap_3),
    .err       (err_3),
    .err_cnt   (err_cnt_3)
  );

endmodule

// File: tb/tb_dual_gray_checker.sv
// Randomised + directed bench for dual_gray_checker with a scoreboard queue
// fed by the driver and drained by an independent monitor.
module tb_dual_gray_checker;

  localparam int TB_ERR_W = 8;
  localparam int ERR_MAX  = (1 << TB_ERR_W) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sample_en = 1'b0;
  logic [3:0]          gray_4 = '0;
  logic [2:0]          gray_3 = '0;
  logic                clr_err = 1'b0;
  logic [3:0]          bin_4;
  logic [2:0]          bin_3;
  logic                step_4, step_3, dir_4, dir_3, wrap_4, wrap_3, err_4, err_3;
  logic [TB_ERR_W-1:0] err_cnt_4, err_cnt_3;

  dual_gray_checker #(.ERR_W(TB_ERR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .gray_4    (gray_4),
    .gray_3    (gray_3),
    .clr_err   (clr_err),
    .bin_4     (bin_4),
    .bin_3     (bin_3),
    .step_4    (step_4),
    .step_3    (step_3),
    .dir_4     (dir_4),
    .dir_3     (dir_3),
    .wrap_4    (wrap_4),
    .wrap_3    (wrap_3),
    .err_4     (err_4),
    .err_3     (err_3),
    .err_cnt_4 (err_cnt_4),
    .err_cnt_3 (err_cnt_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin4; int bin3;
    bit step4; bit step3;
    bit dir4;  bit dir3;
    bit wrap4; bit wrap3;
    bit err4;  bit err3;
    int cnt4;  int cnt3;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model state, per channel (0 = 4-bit, 1 = 3-bit)
  bit m_init[2];
  int m_prev[2];
  int m_bin[2];
  bit m_dir[2];
  int m_cnt[2];
  int cur4 = 0;
  int cur3 = 0;

  function automatic int g2b(input int g, input int w);
    int b;
    b = 0;
    for (int k = 0; k < w; k++) b = b ^ (g >> k);
    return b & ((1 << w) - 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_init[c] = 1'b0; m_prev[c] = 0; m_bin[c] = 0; m_dir[c] = 1'b0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_ch(input int ch, input int g, input bit en, input bit clr,
                          output bit st, output bit wr, output bit er);
    int w;
    int maxv;
    int nb;
    int d;
    w = (ch == 0) ? 4 : 3;
    maxv = (1 << w) - 1;
    st = 1'b0; wr = 1'b0; er = 1'b0;
    if (en) begin
      nb = g2b(g, w);
      if (!m_init[ch]) begin
        m_init[ch] = 1'b1;
        m_prev[ch] = g;
        m_bin[ch]  = nb;
      end else begin
        d = $countones(g ^ m_prev[ch]);
        if (d == 1) begin
          st = 1'b1;
          m_dir[ch] = (nb == ((m_bin[ch] + 1) % (maxv + 1)));
          wr = (m_bin[ch] == maxv && nb == 0) || (m_bin[ch] == 0 && nb == maxv);
          m_bin[ch] = nb;
        end else if (d >= 2) begin
          er = 1'b1;
          m_bin[ch] = nb;
        end
        m_prev[ch] = g;
      end
    end
    if (clr) m_cnt[ch] = 0;
    else if (er && m_cnt[ch] < ERR_MAX) m_cnt[ch] = m_cnt[ch] + 1;
  endtask

  task automatic drive(input bit en, input int g4, input int g3, input bit clr);
    exp_t e;
    bit s, w, r;
    @(negedge clk);
    sample_en = en;
    gray_4    = 4'(g4);
    gray_3    = 3'(g3);
    clr_err   = clr;
    cur4 = g4;
    cur3 = g3;
    model_ch(0, g4, en, clr, s, w, r);
    e.step4 = s; e.wrap4 = w; e.err4 = r;
    e.bin4 = m_bin[0]; e.dir4 = m_dir[0]; e.cnt4 = m_cnt[0];
    model_ch(1, g3, en, clr, s, w, r);
    e.step3 = s; e.wrap3 = w; e.err3 = r;
    e.bin3 = m_bin[1]; e.dir3 = m_dir[1]; e.cnt3 = m_cnt[1];
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    sample_en = 1'b0;
    clr_err   = 1'b0;
  endtask

  task automatic check_zero(input string name);
    bit ok;
    ok = (bin_4 == 0) && (bin_3 == 0) && !step_4 && !step_3 && !dir_4 && !dir_3 &&
         !wrap_4 && !wrap_3 && !err_4 && !err_3 && (err_cnt_4 == 0) && (err_cnt_3 == 0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got bin4=%0d bin3=%0d step=%b%b dir=%b%b wrap=%b%b err=%b%b cnt=%0d/%0d required all zero",
               name, bin_4, bin_3, step_4, step_3, dir_4, dir_3, wrap_4, wrap_3,
               err_4, err_3, err_cnt_4, err_cnt_3);
    end else begin
      $display("%s outputs all zero", name);
    end
  endtask

  function automatic int next_gray(input int cur, input int w);
    int r;
    r = $urandom_range(0, 3);
    if (r <= 1) return cur ^ (1 << $urandom_range(0, w - 1));
    if (r == 2) return cur;
    return $urandom_range(0, (1 << w) - 1);
  endfunction

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      drive($urandom_range(0, 4) != 0, next_gray(cur4, 4), next_gray(cur3, 3),
            $urandom_range(0, 31) == 0);
    end
  endtask

  // Monitor: outputs are registered, compare just after each rising edge.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        ok = (int'(bin_4) == e.bin4) && (int'(bin_3) == e.bin3) &&
             (step_4 == e.step4) && (step_3 == e.step3) &&
             (dir_4 == e.dir4) && (dir_3 == e.dir3) &&
             (wrap_4 == e.wrap4) && (wrap_3 == e.wrap3) &&
             (err_4 == e.err4) && (err_3 == e.err3) &&
             (int'(err_cnt_4) == e.cnt4) && (int'(err_cnt_3) == e.cnt3);
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL txn%0d got bin=%0d/%0d step=%b%b dir=%b%b wrap=%b%b err=%b%b cnt=%0d/%0d required bin=%0d/%0d step=%b%b dir=%b%b wrap=%b%b err=%b%b cnt=%0d/%0d",
                   txn, bin_4, bin_3, step_4, step_3, dir_4, dir_3, wrap_4, wrap_3,
                   err_4, err_3, err_cnt_4, err_cnt_3,
                   e.bin4, e.bin3, e.step4, e.step3, e.dir4, e.dir3, e.wrap4, e.wrap3,
                   e.err4, e.err3, e.cnt4, e.cnt3);
        end else begin
          $display("txn%0d ok bin=%0d/%0d step=%b%b dir=%b%b wrap=%b%b err=%b%b cnt=%0d/%0d",
                   txn, bin_4, bin_3, step_4, step_3, dir_4, dir_3, wrap_4, wrap_3,
                   err_4, err_3, err_cnt_4, err_cnt_3);
        end
      end
    end
  end

  initial begin
    int seq4a[5];
    int seq3[8];
    int seq4b[5];
    int seq4c[4];
    seq4a = '{0, 1, 3, 2, 6};
    seq3  = '{1, 3, 2, 6, 7, 5, 4, 0};
    seq4b = '{2, 3, 1, 0, 8};
    seq4c = '{0, 1, 7, 5};
    model_reset();

    #1 reset = 1'b0;
    #3 check_zero("power_on_reset");
    @(negedge clk);
    reset = 1'b1;

    // Counter-style sequence on the 4-bit stream
    for (int i = 0; i < 5; i++) drive(1'b1, seq4a[i], 0, 1'b0);
    // Full 3-bit cycle ending with the 100 -> 000 wrap
    for (int i = 0; i < 8; i++) drive(1'b1, cur4, seq3[i], 1'b0);
    // Walk down to 0000 then step down through the wrap to 1000
    for (int i = 0; i < 5; i++) drive(1'b1, seq4b[i], cur3, 1'b0);
    // Illegal 0001 -> 0111 then legal 0101
    for (int i = 0; i < 4; i++) drive(1'b1, seq4c[i], cur3, 1'b0);
    // Repeated identical samples and a stalled cycle
    drive(1'b1, cur4, 5, 1'b0);
    drive(1'b1, cur4, 5, 1'b0);
    drive(1'b0, 0, 2, 1'b0);
    drive(1'b1, cur4, 5, 1'b0);
    // Saturation on the 3-bit error counter
    for (int i = 0; i < 300; i++) drive(1'b1, cur4, (i % 2 == 0) ? 0 : 3, 1'b0);
    drive(1'b1, cur4, (cur3 == 0) ? 3 : 0, 1'b1);
    drive(1'b1, cur4, (cur3 == 0) ? 3 : 0, 1'b0);

    random_phase(200);
    drain();

    // Mid-stream asynchronous reset
    #2 reset = 1'b0;
    model_reset();
    #1 check_zero("midstream_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 15, cur3, 1'b0);
    drive(1'b1, 14, cur3, 1'b0);
    random_phase(200);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
